// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction prefetcher. It issues sequential reads to a fixed-latency
//   instruction memory and tracks the reads still in flight. Returned words
//   are parked, tagged with their PC, in a small FIFO that feeds the decoder
//   through a valid/ready handshake. A redirect flushes everything and
//   restarts fetch at a new PC.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   start                    begin fetching at PC 0 (from IDLE or DONE)
//   redirect_valid/_pc       flush and restart fetch at redirect_pc
//   mem_en/mem_addr          memory read strobe and address
//   mem_data                 read data, valid MEM_LATENCY cycles after mem_en
//   out_valid/out_ready      decoder handshake
//   out_pc/out_inst          oldest buffered instruction and its PC
//   busy                     fetch in progress (RUN or DRAIN)
//   done                     program finished (DONE)
module inst_fetch_queue #(
    parameter int INST_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int DEPTH       = 4,
    parameter int MEM_LATENCY = 2,
    parameter int PROG_LEN    = 1024,
    parameter int LOOP        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [INST_WIDTH-1:0] mem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic                  busy,
    output logic                  done
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = $clog2(DEPTH + MEM_LATENCY + 1) + 1;
    localparam bit LOOP_EN = (LOOP != 0);
    // PC compares are one bit wider so PROG_LEN == 2**ADDR_WIDTH still fits.
    localparam logic [ADDR_WIDTH:0] PLEN    = (ADDR_WIDTH+1)'(PROG_LEN);
    localparam logic [ADDR_WIDTH:0] LAST_PC = PLEN - (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e                               state_q, state_d;
    logic [ADDR_WIDTH-1:0]                pc_q, pc_d;
    // vld_pipe_q[k] marks a read issued k+1 cycles ago; the top stage is the
    // one whose data is on mem_data this cycle.
    logic [MEM_LATENCY-1:0]               vld_pipe_q;
    logic [MEM_LATENCY-1:0][ADDR_WIDTH-1:0] pc_pipe_q;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0]     buf_pc_q;
    logic [DEPTH-1:0][INST_WIDTH-1:0]     buf_inst_q;
    logic [PTR_W-1:0]                     rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]                     count_q, count_d;

    logic                                 in_range, push, pop, pipe_drains;
    logic [OCC_W-1:0]                     occ;

    // Credit: buffered entries plus reads in flight. A pop this cycle is not
    // credited, so issue never depends on out_ready.
    always_comb begin
        occ = OCC_W'(count_q);
        for (int i = 0; i < MEM_LATENCY; i++) occ = occ + OCC_W'(vld_pipe_q[i]);
    end

    // After this edge the pipe holds nothing if only the top stage (which
    // retires now) is set and no new read is issued.
    always_comb begin
        pipe_drains = !mem_en;
        for (int i = 0; i < MEM_LATENCY - 1; i++)
            if (vld_pipe_q[i]) pipe_drains = 1'b0;
    end

    assign in_range  = LOOP_EN || ({1'b0, pc_q} < PLEN);
    assign mem_en    = (state_q == S_RUN) && !redirect_valid && in_range &&
                       (occ < OCC_W'(DEPTH));
    assign mem_addr  = pc_q;

    assign out_valid = (count_q != '0) && !redirect_valid;
    assign out_pc    = buf_pc_q[rd_ptr_q];
    assign out_inst  = buf_inst_q[rd_ptr_q];
    assign pop       = out_valid && out_ready;
    assign push      = vld_pipe_q[MEM_LATENCY-1] && !redirect_valid;

    assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
        if (redirect_valid)    count_d = '0;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_RUN: begin
                if (mem_en) begin
                    if ({1'b0, pc_q} >= LAST_PC) begin
                        pc_d = '0;
                        if (!LOOP_EN) state_d = S_DRAIN;
                    end else begin
                        pc_d = pc_q + ADDR_WIDTH'(1);
                    end
                end else if (!in_range) begin
                    // Redirected past the end of the program: nothing to fetch.
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pipe_drains && count_d == '0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // Redirect wins over start and restarts fetch from any state.
        if (redirect_valid) begin
            state_d = S_RUN;
            pc_d    = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Killing the valid bits is what discards stale returns after a flush or
    // reset; the PC tags can keep shifting freely.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= mem_en;
            for (int i = 1; i < MEM_LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pc_pipe_q[0] <= pc_q;
        for (int i = 1; i < MEM_LATENCY; i++) pc_pipe_q[i] <= pc_pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]   <= pc_pipe_q[MEM_LATENCY-1];
            buf_inst_q[wr_ptr_q] <= mem_data;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
    localparam int IW = 32;
    localparam int AW = 10;
    localparam int D  = 4;
    localparam int L  = 2;
    localparam int PL = 8;

    logic          clk = 1'b0;
    logic          rst, start, redirect_valid, out_ready;
    logic [AW-1:0] redirect_pc;
    logic          mem_en, out_valid, busy, done;
    logic [AW-1:0] mem_addr, out_pc;
    logic [IW-1:0] mem_data, out_inst;
    logic          mem_en_l, out_valid_l, busy_l, done_l;
    logic [AW-1:0] mem_addr_l, out_pc_l;
    logic [IW-1:0] mem_data_l, out_inst_l;
    logic [IW-1:0] m0, m1, ml0, ml1;

    int errors = 0;
    int checks = 0;
    logic [AW-1:0] got_pc[$];
    logic [IW-1:0] got_inst[$];
    bit            saw_done;

    always #5 clk = ~clk;

    // Memory model: word at address a is a*3, returned two cycles after mem_en.
    always @(posedge clk) begin
        m0  <= IW'(mem_addr) * 3;
        m1  <= m0;
        ml0 <= IW'(mem_addr_l) * 3;
        ml1 <= ml0;
    end
    assign mem_data   = m1;
    assign mem_data_l = ml1;

    inst_fetch_queue #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(D), .MEM_LATENCY(L),
                       .PROG_LEN(PL), .LOOP(0)) dut (
        .clk(clk), .rst(rst), .start(start), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_data(mem_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .busy(busy), .done(done));

    inst_fetch_queue #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(D), .MEM_LATENCY(L),
                       .PROG_LEN(PL), .LOOP(1)) dut_loop (
        .clk(clk), .rst(rst), .start(start), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .mem_en(mem_en_l), .mem_addr(mem_addr_l),
        .mem_data(mem_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_pc(out_pc_l), .out_inst(out_inst_l), .busy(busy_l), .done(done_l));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        step;
        step;
        rst = 1'b0;
    endtask

    // Records deliveries until done or the cycle budget runs out.
    task automatic collect(input int max_cyc);
        got_pc.delete();
        got_inst.delete();
        saw_done = 1'b0;
        for (int i = 0; i < max_cyc && !saw_done; i++) begin
            #1;
            if (done) saw_done = 1'b1;
            else if (out_valid && out_ready) begin
                got_pc.push_back(out_pc);
                got_inst.push_back(out_inst);
            end
            step;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; redirect_valid = 1'b1; redirect_pc = 5; out_ready = 1'b1;
        step;
        step;
        start = 1'b0; redirect_valid = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0)    begin errors++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (mem_addr !== '0)    begin errors++; $display("FAIL reset_pc got=%0d exp=0", mem_addr); end
        checks++; if (busy_l !== 1'b0)    begin errors++; $display("FAIL reset_loop_busy got=%b exp=0", busy_l); end
        step;
    endtask

    task automatic test_basic;
        logic exp_en, exp_v;
        do_reset;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            start = (cyc == 0);
            #1;
            exp_en = (cyc >= 1 && cyc <= 8);
            exp_v  = (cyc >= 4 && cyc <= 11);
            checks++; if (mem_en !== exp_en) begin errors++; $display("FAIL basic_mem_en cyc=%0d got=%b exp=%b", cyc, mem_en, exp_en); end
            if (exp_en) begin
                checks++; if (mem_addr !== AW'(cyc-1)) begin errors++; $display("FAIL basic_mem_addr cyc=%0d got=%0d exp=%0d", cyc, mem_addr, cyc-1); end
            end
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL basic_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v); end
            if (exp_v) begin
                checks++;
                if (out_pc !== AW'(cyc-4) || out_inst !== IW'((cyc-4)*3)) begin
                    errors++; $display("FAIL basic_out cyc=%0d got pc=%0d inst=%0d exp pc=%0d inst=%0d", cyc, out_pc, out_inst, cyc-4, (cyc-4)*3);
                end
            end
            checks++; if (done !== (cyc >= 12)) begin errors++; $display("FAIL basic_done cyc=%0d got=%b exp=%b", cyc, done, cyc >= 12); end
            checks++; if (busy !== (cyc >= 1 && cyc <= 11)) begin errors++; $display("FAIL basic_busy cyc=%0d got=%b", cyc, busy); end
            step;
        end
        start = 1'b0;
    endtask

    task automatic test_backpressure;
        int pulses;
        pulses = 0;
        do_reset;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            start = (cyc == 0);
            #1;
            if (mem_en) pulses++;
            if (cyc >= 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== '0 || out_inst !== '0) begin
                    errors++; $display("FAIL bp_hold cyc=%0d got valid=%b pc=%0d inst=%0d exp valid=1 pc=0 inst=0", cyc, out_valid, out_pc, out_inst);
                end
            end
            step;
        end
        start = 1'b0;
        checks++; if (pulses != D) begin errors++; $display("FAIL bp_pulses got=%0d exp=%0d", pulses, D); end
        out_ready = 1'b1;
        collect(40);
        checks++; if (!saw_done) begin errors++; $display("FAIL bp_done got=0 exp=1"); end
        checks++; if (got_pc.size() != PL) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got_pc.size(), PL); end
        for (int i = 0; i < got_pc.size(); i++) begin
            checks++;
            if (got_pc[i] !== AW'(i) || got_inst[i] !== IW'(i*3)) begin
                errors++; $display("FAIL bp_order idx=%0d got pc=%0d inst=%0d exp pc=%0d inst=%0d", i, got_pc[i], got_inst[i], i, i*3);
            end
        end
    endtask

    task automatic test_redirect;
        do_reset;
        out_ready = 1'b1;
        start = 1'b1; step; start = 1'b0;
        step; step;
        redirect_valid = 1'b1; redirect_pc = 5;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_low got=%b exp=0", out_valid); end
        step;
        redirect_valid = 1'b0;
        collect(40);
        checks++; if (!saw_done) begin errors++; $display("FAIL redir_done got=0 exp=1"); end
        checks++; if (got_pc.size() != 3) begin errors++; $display("FAIL redir_count got=%0d exp=3", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            checks++;
            if (got_pc[i] !== AW'(5+i) || got_inst[i] !== IW'((5+i)*3)) begin
                errors++; $display("FAIL redir_order idx=%0d got pc=%0d exp pc=%0d", i, got_pc[i], 5+i);
            end
        end
    endtask

    // Redirect while PC 1 sits at the head of the buffer.
    task automatic test_redirect_late;
        do_reset;
        out_ready = 1'b1;
        start = 1'b1; step; start = 1'b0;
        for (int c = 1; c < 5; c++) step;
        redirect_valid = 1'b1; redirect_pc = 2;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL late_valid_low got=%b exp=0", out_valid); end
        step;
        redirect_valid = 1'b0;
        collect(40);
        checks++; if (!saw_done) begin errors++; $display("FAIL late_done got=0 exp=1"); end
        checks++; if (got_pc.size() != 6) begin errors++; $display("FAIL late_count got=%0d exp=6", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            checks++;
            if (got_pc[i] !== AW'(2+i) || got_inst[i] !== IW'((2+i)*3)) begin
                errors++; $display("FAIL late_order idx=%0d got pc=%0d exp pc=%0d", i, got_pc[i], 2+i);
            end
        end
    endtask

    task automatic test_redirect_idle;
        bit en_seen, v_seen;
        do_reset;
        out_ready = 1'b1;
        start = 1'b1; redirect_valid = 1'b1; redirect_pc = 6;
        step;
        start = 1'b0; redirect_valid = 1'b0;
        collect(40);
        checks++; if (!saw_done) begin errors++; $display("FAIL idle_redir_done got=0 exp=1"); end
        checks++; if (got_pc.size() != 2) begin errors++; $display("FAIL idle_redir_count got=%0d exp=2", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            checks++;
            if (got_pc[i] !== AW'(6+i)) begin errors++; $display("FAIL idle_redir_order idx=%0d got pc=%0d exp pc=%0d", i, got_pc[i], 6+i); end
        end
        // From DONE, redirect past the end of the program.
        redirect_valid = 1'b1; redirect_pc = PL;
        step;
        redirect_valid = 1'b0;
        en_seen = 1'b0; v_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            en_seen |= mem_en;
            v_seen  |= out_valid;
            step;
        end
        checks++; if (en_seen) begin errors++; $display("FAIL oor_mem_en got=1 exp=0"); end
        checks++; if (v_seen)  begin errors++; $display("FAIL oor_out_valid got=1 exp=0"); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL oor_done got=%b exp=1", done); end
    endtask

    task automatic test_loop;
        int  n;
        bit  done_seen;
        do_reset;
        out_ready = 1'b1;
        start = 1'b1; step; start = 1'b0;
        n = 0; done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            done_seen |= done_l;
            if (out_valid_l) begin
                checks++;
                if (out_pc_l !== AW'(n % PL) || out_inst_l !== IW'((n % PL)*3)) begin
                    errors++; $display("FAIL loop_order idx=%0d got pc=%0d exp pc=%0d", n, out_pc_l, n % PL);
                end
                n++;
            end
            step;
        end
        checks++; if (n != 37) begin errors++; $display("FAIL loop_count got=%0d exp=37", n); end
        checks++; if (done_seen) begin errors++; $display("FAIL loop_done got=1 exp=0"); end
        checks++; if (busy_l !== 1'b1) begin errors++; $display("FAIL loop_busy got=%b exp=1", busy_l); end
    endtask

    task automatic test_mid_reset;
        do_reset;
        out_ready = 1'b1;
        start = 1'b1; step; start = 1'b0;
        for (int c = 1; c < 6; c++) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0)    begin errors++; $display("FAIL mrst_mem_en got=%b exp=0", mem_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mrst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL mrst_done got=%b exp=0", done); end
        checks++; if (mem_addr !== '0)    begin errors++; $display("FAIL mrst_pc got=%0d exp=0", mem_addr); end
        step;
        for (int c = 8; c < 12; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0 || mem_en !== 1'b0) begin
                errors++; $display("FAIL mrst_stale cyc=%0d got valid=%b en=%b exp 0 0", c, out_valid, mem_en);
            end
            step;
        end
    endtask

    task automatic test_random;
        int  exp_pc, issued;
        bit  fin;
        do_reset;
        for (int r = 0; r < 1000; r++) begin
            exp_pc = 0; issued = 0; fin = 1'b0;
            start = 1'b1;
            for (int c = 0; c < 200 && !fin; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                if (c > 0 && done) fin = 1'b1;
                else begin
                    if (mem_en) issued++;
                    if (out_valid && out_ready) begin
                        checks++;
                        if (out_pc !== AW'(exp_pc) || out_inst !== IW'(exp_pc*3)) begin
                            errors++; $display("FAIL rand_order run=%0d got pc=%0d exp pc=%0d", r, out_pc, exp_pc);
                        end
                        exp_pc++;
                    end
                    checks++;
                    if (issued - exp_pc > D) begin
                        errors++; $display("FAIL rand_occupancy run=%0d got=%0d max=%0d", r, issued - exp_pc, D);
                    end
                end
                step;
                start = 1'b0;
            end
            checks++;
            if (!fin || exp_pc != PL) begin
                errors++; $display("FAIL rand_run run=%0d got done=%b delivered=%0d exp done=1 delivered=%0d", r, fin, exp_pc, PL);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        #1;
        test_reset;
        test_basic;
        test_backpressure;
        test_redirect;
        test_redirect_late;
        test_redirect_idle;
        test_loop;
        test_mid_reset;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
